// File: rtl/arilla_arb_pkg.sv
// Shared types and sizing helpers for the arilla system-bus arbiter.
package arilla_arb_pkg;

    // Arbiter FSM states; encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Number of byte-enable lanes for a given data width.
    function automatic int be_width(input int data_width, input int byte_size);
        return data_width / byte_size;
    endfunction

    // Timeout counter width; at least one bit so a disabled timeout still
    // leaves a legal (unused) counter.
    function automatic int tmo_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a master index.
    function automatic int idx_width(input int num_masters);
        int w;
        w = $clog2(num_masters);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arilla_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: starting one past ptr_i and wrapping,
// the first asserted request wins. Returns a one-hot grant and its index.
module rr_picker #(
    parameter int N    = 2,
    parameter int IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    // Walk the masters in priority order and keep the first requester found.
    always_comb begin
        int   cand;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(ptr_i) + off) % N;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IdxW'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter sharing one arilla system-bus target port between
// several masters. One outstanding transaction; optional per-master lock;
// response timeout with abort.
//
// Handshake: a master raises m_req with a stable payload and holds it until
// it sees a one-cycle m_ack or m_err pulse on its own bit. Towards the target,
// s_req is a one-cycle pulse with the payload held stable from ISSUE through
// RESP; the target answers with s_ack/s_err (sampled only in WAIT), and a
// one-cycle s_abort tells it to drop the transaction on timeout.
module arilla_bus_arbiter
    import arilla_arb_pkg::*;
#(
    parameter int NumMasters    = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int ByteSize      = 8,
    parameter int TimeoutCycles = 255,
    localparam int BeWidth      = be_width(DataWidth, ByteSize)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumMasters-1:0]            m_req,
    input  logic [NumMasters-1:0]            m_lock,
    input  logic [NumMasters-1:0]            m_we,
    input  logic [NumMasters*AddressWidth-1:0] m_addr,
    input  logic [NumMasters*DataWidth-1:0]  m_wdata,
    input  logic [NumMasters*BeWidth-1:0]    m_be,
    output logic [NumMasters-1:0]            m_ack,
    output logic [NumMasters-1:0]            m_err,
    output logic [DataWidth-1:0]             m_rdata,
    output logic [NumMasters-1:0]            m_grant,
    output logic                             s_req,
    output logic                             s_we,
    output logic [AddressWidth-1:0]          s_addr,
    output logic [DataWidth-1:0]             s_wdata,
    output logic [BeWidth-1:0]               s_be,
    input  logic                             s_ack,
    input  logic                             s_err,
    input  logic [DataWidth-1:0]             s_rdata,
    output logic                             s_abort,
    output logic [1:0]                       dbg_state
);

    localparam int IdxW    = idx_width(NumMasters);
    localparam int CntW    = tmo_width(TimeoutCycles);
    localparam int TmoLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         ptr_q, ptr_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic [NumMasters-1:0]   grant_q, grant_d;
    logic                    lock_q, lock_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    wdata_q, wdata_d;
    logic [BeWidth-1:0]      be_q, be_d;
    logic [DataWidth-1:0]    rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [NumMasters-1:0]   pick_grant;
    logic [IdxW-1:0]         pick_idx;
    logic                    pick_valid;

    logic                    win_valid;
    logic [IdxW-1:0]         win_idx;
    logic [NumMasters-1:0]   win_grant;
    logic                    tmo_hit;

    rr_picker #(
        .N    (NumMasters),
        .IdxW (IdxW)
    ) u_picker (
        .req_i   (m_req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Timeout expiry: last permitted WAIT cycle; never fires when disabled.
    assign tmo_hit = (TimeoutCycles != 0) && (cnt_q == CntW'(TmoLast));

    // Next-state logic: arbitration, payload capture, response capture.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        win_valid = 1'b0;
        win_idx   = '0;
        win_grant = '0;

        case (state_q)
            IDLE: begin
                if (lock_q && m_req[owner_q]) begin
                    // Locked owner keeps the bus while it keeps requesting.
                    win_valid = 1'b1;
                    win_idx   = owner_q;
                    win_grant = grant_q;
                end else begin
                    // Lock lapses as soon as its owner stops requesting.
                    lock_d    = 1'b0;
                    win_valid = pick_valid;
                    win_idx   = pick_idx;
                    win_grant = pick_grant;
                end
                if (win_valid) begin
                    owner_d = win_idx;
                    grant_d = win_grant;
                    we_d    = m_we[win_idx];
                    addr_d  = m_addr[int'(win_idx)*AddressWidth +: AddressWidth];
                    wdata_d = m_wdata[int'(win_idx)*DataWidth +: DataWidth];
                    be_d    = m_be[int'(win_idx)*BeWidth +: BeWidth];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (s_ack || s_err) begin
                    // Error dominates a simultaneous ack; its data is dropped.
                    err_d   = s_err;
                    rdata_d = s_err ? '0 : s_rdata;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                lock_d  = m_lock[owner_q];
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IdxW'(NumMasters - 1);
            owner_q <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Output decode from registered state; only s_abort looks at live inputs
    // so that a response on the expiry cycle suppresses the abort.
    always_comb begin
        s_req     = (state_q == ISSUE);
        s_we      = we_q;
        s_addr    = addr_q;
        s_wdata   = wdata_q;
        s_be      = be_q;
        s_abort   = (state_q == WAIT) && tmo_hit && !s_ack && !s_err;
        m_ack     = (state_q == RESP && !err_q) ? grant_q : '0;
        m_err     = (state_q == RESP &&  err_q) ? grant_q : '0;
        m_rdata   = (state_q == RESP && !err_q) ? rdata_q : '0;
        m_grant   = (state_q == IDLE && !lock_q) ? '0 : grant_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed bench for arilla_bus_arbiter: latency sequence, a table of
// arbitration/lock/response vectors, timeout and mid-transaction reset.
module tb_arilla_bus_arbiter;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  m_req, m_lock, m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*BW-1:0] m_be;
  logic [N-1:0]  m_ack, m_err, m_grant;
  logic [DW-1:0] m_rdata;
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [BW-1:0] s_be;
  logic          s_ack, s_err;
  logic [DW-1:0] s_rdata;
  logic          s_abort;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  logic [AW-1:0] e_addr [N];
  logic [DW-1:0] e_wdata[N];
  logic [BW-1:0] e_be   [N];

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  lock;
    logic [1:0]  we;
    int          delay;
    logic        rsp_ack;
    logic        rsp_err;
    logic [31:0] rd;
    logic [1:0]  exp_idle;
    int          exp_g;
    logic        exp_ok;
  } vec_t;

  vec_t vecs[13];

  arilla_bus_arbiter #(
    .NumMasters(N), .DataWidth(DW), .AddressWidth(AW), .ByteSize(8), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_lock(m_lock), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .m_grant(m_grant),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata), .s_abort(s_abort),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    m_req = '0; m_lock = '0; m_we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the one-cycle s_req pulse; returns at that negedge.
  task automatic wait_sreq(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = s_req;
    end
    check({name, "_sreq_seen"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ack"},   {30'b0, m_ack},   32'd0);
    check({name, "_err"},   {30'b0, m_err},   32'd0);
    check({name, "_grant"}, {30'b0, m_grant}, 32'd0);
    check({name, "_sreq"},  {31'b0, s_req},   32'd0);
    check({name, "_abort"}, {31'b0, s_abort}, 32'd0);
    check({name, "_saddr"}, s_addr,           32'd0);
    check({name, "_rdata"}, m_rdata,          32'd0);
    check({name, "_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  // Apply one table vector from an IDLE negedge; returns at the next IDLE negedge.
  task automatic run_vec(input int k, input vec_t v);
    string t;
    logic [1:0] g1h;
    t = $sformatf("v%0d", k);
    g1h = 2'b01 << v.exp_g;
    check({t, "_idle_grant"}, {30'b0, m_grant}, {30'b0, v.exp_idle});
    m_req = v.req; m_lock = v.lock; m_we = v.we;
    if (v.exp_ok) exp_q.push_back(v.rd);
    wait_sreq(t);
    check({t, "_grant"}, {30'b0, m_grant}, {30'b0, g1h});
    check({t, "_saddr"}, s_addr, e_addr[v.exp_g]);
    check({t, "_swdata"}, s_wdata, e_wdata[v.exp_g]);
    check({t, "_sbe"}, {28'b0, s_be}, {28'b0, e_be[v.exp_g]});
    check({t, "_swe"}, {31'b0, s_we}, {31'b0, v.we[v.exp_g]});
    for (int i = 0; i < v.delay; i++) begin
      @(negedge clk);
      check({t, "_wait_abort"}, {31'b0, s_abort}, 32'd0);
    end
    @(negedge clk);
    s_ack = v.rsp_ack; s_err = v.rsp_err; s_rdata = v.rd;
    #1;
    check({t, "_rsp_abort"}, {31'b0, s_abort}, 32'd0);
    @(negedge clk);
    s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
    if (v.exp_ok) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check({t, "_ack"}, {30'b0, m_ack}, {30'b0, g1h});
      check({t, "_err"}, {30'b0, m_err}, 32'd0);
      check({t, "_rdata"}, m_rdata, e);
    end else begin
      check({t, "_ack"}, {30'b0, m_ack}, 32'd0);
      check({t, "_err"}, {30'b0, m_err}, {30'b0, g1h});
    end
    @(negedge clk);
    check({t, "_pulse_end"}, {30'b0, (m_ack | m_err)}, 32'd0);
  endtask

  initial begin
    // req  lock  we   dly ack err rdata          idle  g  ok
    vecs[0]  = '{2'b11, 2'b00, 2'b00, 0, 1'b1, 1'b0, 32'hA000_0000, 2'b00, 0, 1'b1};
    vecs[1]  = '{2'b11, 2'b00, 2'b10, 1, 1'b1, 1'b0, 32'hA000_0001, 2'b00, 1, 1'b1};
    vecs[2]  = '{2'b11, 2'b00, 2'b01, 2, 1'b1, 1'b0, 32'hA000_0002, 2'b00, 0, 1'b1};
    vecs[3]  = '{2'b11, 2'b00, 2'b00, 0, 1'b1, 1'b0, 32'hA000_0003, 2'b00, 1, 1'b1};
    vecs[4]  = '{2'b11, 2'b10, 2'b00, 0, 1'b1, 1'b0, 32'hA000_0004, 2'b00, 0, 1'b1};
    vecs[5]  = '{2'b11, 2'b10, 2'b00, 1, 1'b1, 1'b0, 32'hA000_0005, 2'b00, 1, 1'b1};
    vecs[6]  = '{2'b11, 2'b10, 2'b11, 0, 1'b1, 1'b0, 32'hA000_0006, 2'b10, 1, 1'b1};
    vecs[7]  = '{2'b11, 2'b10, 2'b00, 2, 1'b1, 1'b0, 32'hA000_0007, 2'b10, 1, 1'b1};
    vecs[8]  = '{2'b01, 2'b00, 2'b00, 0, 1'b1, 1'b0, 32'hA000_0008, 2'b10, 0, 1'b1};
    vecs[9]  = '{2'b01, 2'b00, 2'b00, 1, 1'b0, 1'b1, 32'hA000_0009, 2'b00, 0, 1'b0};
    vecs[10] = '{2'b10, 2'b00, 2'b00, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00, 1, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 2'b00, 3, 1'b1, 1'b0, 32'h5A5A_5A5A, 2'b00, 0, 1'b1};
    vecs[12] = '{2'b10, 2'b01, 2'b10, 0, 1'b1, 1'b0, 32'hA000_000C, 2'b00, 1, 1'b1};

    e_addr[0]  = 32'h1000_0100; e_addr[1]  = 32'h2000_0040;
    e_wdata[0] = 32'hAAAA_0000; e_wdata[1] = 32'hBBBB_0001;
    e_be[0]    = 4'h3;          e_be[1]    = 4'hC;

    drive_idle();
    m_addr = '0; m_wdata = '0; m_be = '0;
    rst_n = 1'b0;
    #12;
    check_outputs_zero("reset");
    do_reset();

    // Single read: request at cycle 0, s_req at 1, s_ack during 3, m_ack at 4.
    m_addr[31:0] = 32'h0000_0100;
    m_req = 2'b01;
    @(negedge clk);
    check("rd_sreq_c1", {31'b0, s_req}, 32'd1);
    check("rd_saddr_c1", s_addr, 32'h0000_0100);
    check("rd_grant_c1", {30'b0, m_grant}, 32'd1);
    @(negedge clk);
    check("rd_sreq_c2", {31'b0, s_req}, 32'd0);
    @(negedge clk);
    check("rd_ack_c3", {30'b0, m_ack}, 32'd0);
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rd_ack_c4", {30'b0, m_ack}, 32'd1);
    check("rd_rdata_c4", m_rdata, 32'hDEAD_BEEF);
    s_ack = 1'b0; s_rdata = '0; m_req = 2'b00;
    @(negedge clk);
    check("rd_ack_c5", {30'b0, m_ack}, 32'd0);
    check("rd_grant_c5", {30'b0, m_grant}, 32'd0);

    // Table: fairness, lock, error/ack collisions, expiry-cycle response.
    do_reset();
    m_addr  = {e_addr[1], e_addr[0]};
    m_wdata = {e_wdata[1], e_wdata[0]};
    m_be    = {e_be[1], e_be[0]};
    for (int k = 0; k < 13; k++) run_vec(k, vecs[k]);

    // Timeout: no response, abort on the 4th WAIT cycle, m_err next; late ack ignored.
    check("tmo_idle_grant", {30'b0, m_grant}, 32'd0);
    m_req = 2'b01; m_lock = 2'b00; m_we = 2'b00;
    wait_sreq("tmo");
    check("tmo_grant", {30'b0, m_grant}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tmo_abort_early", {31'b0, s_abort}, 32'd0);
    end
    @(negedge clk);
    check("tmo_abort", {31'b0, s_abort}, 32'd1);
    check("tmo_err_early", {30'b0, m_err}, 32'd0);
    @(negedge clk);
    check("tmo_m_err", {30'b0, m_err}, 32'd1);
    check("tmo_m_ack", {30'b0, m_ack}, 32'd0);
    check("tmo_abort_pulse", {31'b0, s_abort}, 32'd0);
    s_ack = 1'b1; s_rdata = 32'h1234_5678; m_req = 2'b00;
    @(negedge clk);
    check("late_ack_idle", {30'b0, (m_ack | m_err)}, 32'd0);
    check("late_ack_state", {30'b0, dbg_state}, 32'd0);
    @(negedge clk);
    check("late_ack_sreq", {31'b0, s_req}, 32'd0);
    check("late_ack_ack", {30'b0, (m_ack | m_err)}, 32'd0);
    s_ack = 1'b0; s_rdata = '0;

    // Reset asserted in WAIT: outputs drop at once; master 0 first afterwards.
    m_req = 2'b10;
    wait_sreq("rst");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_wait");
    repeat (2) @(negedge clk);
    check("rst_no_ack", {30'b0, (m_ack | m_err)}, 32'd0);
    m_req = 2'b11;
    rst_n = 1'b1;
    wait_sreq("rst_after");
    check("rst_after_grant", {30'b0, m_grant}, 32'd1);
    @(negedge clk);
    s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
    @(negedge clk);
    check("rst_after_ack", {30'b0, m_ack}, 32'd1);
    check("rst_after_rdata", m_rdata, 32'hCAFE_0001);
    drive_idle();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
